// File: rtl/div_float_arbiter_if.sv
// Bundle of requester-side and divider-side signals for the shared floating-point divider arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the divider.
interface div_float_arbiter_if #(
    parameter int FLOAT_WIDTH = 64,
    parameter int NUM_REQ     = 4
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1;
    logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2;
    logic [NUM_REQ-1:0]             ack;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [FLOAT_WIDTH-1:0]         resp_result;
    logic [5:0]                     resp_flags;
    logic                           busy;
    logic                           div_start;
    logic [FLOAT_WIDTH-1:0]         div_op1;
    logic [FLOAT_WIDTH-1:0]         div_op2;
    logic [FLOAT_WIDTH-1:0]         div_out;
    logic [4:0]                     div_flags;
    logic                           div_done;

    modport master (
        output req, req_op1, req_op2, div_out, div_flags, div_done,
        input  ack, resp_valid, resp_result, resp_flags, busy, div_start, div_op1, div_op2
    );

    modport slave (
        input  req, req_op1, req_op2, div_out, div_flags, div_done,
        output ack, resp_valid, resp_result, resp_flags, busy, div_start, div_op1, div_op2
    );
endinterface

// File: rtl/div_float_arbiter.sv
// Round-robin arbiter that shares one floating-point divider among NUM_REQ requesters,
// with a watchdog that returns a NaN/timeout result when the divider never finishes.
module div_float_arbiter #(
    parameter int FLOAT_WIDTH = 64,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    div_float_arbiter_if.slave  bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1) + 1;
    localparam int EXP_W  = (FLOAT_WIDTH == 32) ? 8 : 11;
    localparam int FRAC_W = FLOAT_WIDTH - 1 - EXP_W;

    // Negative quiet NaN: sign 1, exponent all ones, fraction MSB set.
    localparam logic [FLOAT_WIDTH-1:0] NAN_VAL =
        {1'b1, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [5:0] TIMEOUT_FLAGS = 6'b101000;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [FLOAT_WIDTH-1:0] r_op1;
    logic [FLOAT_WIDTH-1:0] r_op2;
    logic [FLOAT_WIDTH-1:0] r_result;
    logic [5:0]             r_flags;
    logic [CNT_W-1:0]       r_cnt;

    logic [IDX_W-1:0]       w_rr_idx;
    logic                   w_rr_found;
    logic                   w_done_ok;
    logic                   w_timeout;

    // Search starts one past the last winner and wraps, so every requester waits at most NUM_REQ-1 grants.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_rr_idx   = r_last_grant;
        w_rr_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(r_last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!w_rr_found && bus.req[cand_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = cand_idx;
            end
        end
    end

    // A done level still high from the previous operation is masked in the first WAIT cycle (r_cnt == 0).
    assign w_done_ok = bus.div_done && (r_cnt != '0);
    assign w_timeout = (r_cnt + 1'b1) == CNT_W'(TIMEOUT);

    always_comb begin
        w_next_state   = r_state;
        bus.ack        = '0;
        bus.resp_valid = '0;
        bus.div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rr_found) begin
                    w_next_state          = START;
                    bus.ack[w_rr_idx]     = ~rst;
                end
            end
            START: begin
                bus.div_start = 1'b1;
                w_next_state  = WAIT;
            end
            WAIT: begin
                if (w_done_ok || w_timeout) w_next_state = RESP;
            end
            RESP: begin
                bus.resp_valid[r_grant_idx] = 1'b1;
                w_next_state                = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.div_op1     = r_op1;
    assign bus.div_op2     = r_op2;
    assign bus.resp_result = r_result;
    assign bus.resp_flags  = r_flags;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_grant_idx  <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_rr_found) begin
                        r_grant_idx  <= w_rr_idx;
                        r_last_grant <= w_rr_idx;
                        r_op1        <= bus.req_op1[w_rr_idx*FLOAT_WIDTH +: FLOAT_WIDTH];
                        r_op2        <= bus.req_op2[w_rr_idx*FLOAT_WIDTH +: FLOAT_WIDTH];
                    end
                end
                START: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ok) begin
                        r_result <= bus.div_out;
                        r_flags  <= {1'b0, bus.div_flags};
                    end else if (w_timeout) begin
                        r_result <= NAN_VAL;
                        r_flags  <= TIMEOUT_FLAGS;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_float_arbiter.sv
// Directed bench for div_float_arbiter: a behavioural divider answers each div_start, and
// expected grants/results are queued at ack time and popped when resp_valid appears.
module tb_div_float_arbiter;
    localparam int FW = 64;
    localparam int NR = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_float_arbiter_if #(.FLOAT_WIDTH(FW), .NUM_REQ(NR)) bus ();

    div_float_arbiter #(.FLOAT_WIDTH(FW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          idx;
        logic [63:0] result;
        logic [5:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          lg_m;
    logic [63:0] op1_tab[NR];
    logic [63:0] op2_tab[NR];
    logic [63:0] res_tab[NR];

    // Divider model controls
    int          model_lat   = 0;
    bit          stale_mode  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] mask);
        int cand;
        for (int k = 1; k <= NR; k++) begin
            cand = (lg_m + k) % NR;
            if (mask[cand[1:0]]) return cand;
        end
        return -1;
    endfunction

    // Behavioural divider: done rises model_lat cycles after div_start (never when 0).
    // In stale mode the previous done level is held through the first WAIT cycle with junk data.
    initial begin
        int          m_left;
        bit          m_active;
        int          m_stale;
        logic [63:0] m_q;
        m_left = 0; m_active = 1'b0; m_stale = 0; m_q = '0;
        bus.div_done  = 1'b0;
        bus.div_out   = '0;
        bus.div_flags = '0;
        forever begin
            @(negedge clk);
            if (bus.div_start) begin
                m_q      = $realtobits($bitstoreal(bus.div_op1) / $bitstoreal(bus.div_op2));
                m_left   = model_lat;
                m_active = (model_lat > 0);
                if (stale_mode) begin
                    bus.div_done  = 1'b1;
                    bus.div_out   = 64'hBAD0_BAD0_BAD0_BAD0;
                    bus.div_flags = 5'b11111;
                    m_stale       = 2;
                end else begin
                    bus.div_done = 1'b0;
                end
            end else begin
                if (m_stale > 0) begin
                    m_stale--;
                    if (m_stale == 0) begin
                        bus.div_done  = 1'b0;
                        bus.div_out   = '0;
                        bus.div_flags = '0;
                    end
                end
                if (m_active) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active      = 1'b0;
                        bus.div_done  = 1'b1;
                        bus.div_out   = m_q;
                        bus.div_flags = '0;
                    end
                end
            end
        end
    end

    // Starts and ends on an IDLE-cycle sample point. lat == 0 means the divider never answers.
    task automatic run_txn(input logic [3:0] mask, input int lat, input bit stale, input bit hold_req);
        int   gi;
        int   lat_seen;
        bit   ack_seen;
        exp_t e;
        gi         = rr_pick(mask);
        lg_m       = gi;
        model_lat  = lat;
        stale_mode = stale;
        bus.req    = mask;
        #1;
        check("ack_grant", {60'd0, bus.ack}, 64'd1 << gi);
        check("busy_idle", {63'd0, bus.busy}, 64'd0);
        e.idx = gi;
        if (lat == 0) begin
            e.result = 64'hFFF8_0000_0000_0000;
            e.flags  = 6'b101000;
        end else begin
            e.result = res_tab[gi];
            e.flags  = 6'b000000;
        end
        exp_q.push_back(e);

        step();
        if (!hold_req) bus.req = '0;
        check("div_start", {63'd0, bus.div_start}, 64'd1);
        check("start_ack_quiet", {60'd0, bus.ack}, 64'd0);
        check("div_op1", bus.div_op1, op1_tab[gi]);

        ack_seen = 1'b0;
        lat_seen = -1;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 1) check("start_one_cycle", {63'd0, bus.div_start}, 64'd0);
            if (bus.ack != '0) ack_seen = 1'b1;
            if (bus.resp_valid != '0) begin
                lat_seen = k;
                break;
            end
        end
        check("ack_quiet", {63'd0, ack_seen}, 64'd0);
        check("latency", 64'(lat_seen), (lat == 0) ? 64'(TO + 1) : 64'(lat + 1));
        e = exp_q.pop_front();
        check("resp_valid", {60'd0, bus.resp_valid}, 64'd1 << e.idx);
        check("resp_result", bus.resp_result, e.result);
        check("resp_flags", {58'd0, bus.resp_flags}, {58'd0, e.flags});
        check("op2_stable", bus.div_op2, op2_tab[gi]);
        stale_mode = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        lg_m = NR - 1;
    endtask

    initial begin
        bit rv_seen;
        op1_tab[0] = 64'h4018_0000_0000_0000; op2_tab[0] = 64'h4000_0000_0000_0000; res_tab[0] = 64'h4008_0000_0000_0000;
        op1_tab[1] = 64'h4024_0000_0000_0000; op2_tab[1] = 64'h4010_0000_0000_0000; res_tab[1] = 64'h4004_0000_0000_0000;
        op1_tab[2] = 64'h3FF0_0000_0000_0000; op2_tab[2] = 64'h4010_0000_0000_0000; res_tab[2] = 64'h3FD0_0000_0000_0000;
        op1_tab[3] = 64'h401C_0000_0000_0000; op2_tab[3] = 64'h4000_0000_0000_0000; res_tab[3] = 64'h400C_0000_0000_0000;
        for (int i = 0; i < NR; i++) begin
            bus.req_op1[i*FW +: FW] = op1_tab[i];
            bus.req_op2[i*FW +: FW] = op2_tab[i];
        end
        rst     = 1'b1;
        bus.req = 4'b1111;
        lg_m    = NR - 1;
        repeat (3) step();

        // Reset state, with requests pending while reset is held
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_ack", {60'd0, bus.ack}, 64'd0);
        check("rst_div_start", {63'd0, bus.div_start}, 64'd0);
        check("rst_resp_valid", {60'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_result", bus.resp_result, 64'd0);
        check("rst_resp_flags", {58'd0, bus.resp_flags}, 64'd0);
        check("rst_div_op1", bus.div_op1, 64'd0);
        bus.req = '0;
        rst     = 1'b0;

        // Single request: 6.0 / 2.0 with a 60-cycle divider
        run_txn(4'b0001, 60, 1'b0, 1'b0);

        // Contention from reset: requests held, grants rotate 0,1,2,3,0
        do_reset();
        run_txn(4'b1111, 3, 1'b0, 1'b1);
        run_txn(4'b1111, 4, 1'b0, 1'b1);
        run_txn(4'b1111, 5, 1'b0, 1'b1);
        run_txn(4'b1111, 2, 1'b0, 1'b1);
        run_txn(4'b1111, 7, 1'b0, 1'b1);

        // Skip: grant 1, then lone requester 0, then 3 wins over 0
        run_txn(4'b0010, 3, 1'b0, 1'b0);
        run_txn(4'b0001, 3, 1'b0, 1'b0);
        run_txn(4'b1001, 3, 1'b0, 1'b0);

        // Stale done held into the first WAIT cycle
        run_txn(4'b0100, 6, 1'b1, 1'b0);

        // Divider never answers
        run_txn(4'b0001, 0, 1'b0, 1'b0);

        // Reset 20 cycles after div_start abandons the transaction
        lg_m      = rr_pick(4'b0010);
        model_lat = 0;
        bus.req   = 4'b0010;
        #1;
        check("abort_ack", {60'd0, bus.ack}, 64'd1 << lg_m);
        step();
        bus.req = '0;
        rv_seen = 1'b0;
        repeat (20) begin
            step();
            if (bus.resp_valid != '0) rv_seen = 1'b1;
        end
        do_reset();
        if (bus.resp_valid != '0) rv_seen = 1'b1;
        check("abort_no_resp", {63'd0, rv_seen}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_result_cleared", bus.resp_result, 64'd0);
        run_txn(4'b0100, 5, 1'b0, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
